pipelined_addsub: RTL and testbench

- Parametrised, carry-pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output.
- Next generation of the team's single-cycle 32-bit adder. Adds configurable width, segmented carry pipelining, add/sub mode, a signed-overflow flag and backpressure.
- Sits between operand-issue logic and result consumers in the datapath. Sustains one operation per cycle when not stalled.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_segment.sv | 44 ++++
 rtl/pipelined_addsub.sv | 124 ++++++++++++
 tb/tb_pipelined_addsub.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: default geometry, add/sub mode encodings, segment width helper.
package addsub_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   // Encoding of the in_sub control bit.
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Bits handled by each carry segment. WIDTH must be a multiple of STAGES.
   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// One registered carry segment: SEG-bit a + b + cin, registered sum and carry out.
// Latency: 1 cycle, register updates only when en=1.
// Backpressure: en=0 holds sum/cout/c_msb unchanged.
// Ports: clk, rst (sync, active-high), en, a, b, cin -> sum, cout, c_msb
//        (c_msb = carry into bit SEG-1, used by the top segment for overflow).
module addsub_segment
   import addsub_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           c_msb
);

   logic [SEG:0] total;
   logic         c_msb_d;

   always_comb begin
      total   = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
      // The carry that entered the MSB is recovered from the MSB sum bit:
      // s = a ^ b ^ c  =>  c = s ^ a ^ b. Works for SEG=1 as well (c = cin).
      c_msb_d = total[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum   <= '0;
         cout  <= 1'b0;
         c_msb <= 1'b0;
      end else if (en) begin
         sum   <= total[SEG-1:0];
         cout  <= total[SEG];
         c_msb <= c_msb_d;
      end
   end

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined two's-complement adder/subtractor, STAGES segments of WIDTH/STAGES bits.
// Latency: STAGES cycles from acceptance to out_valid; 1 beat/cycle throughput.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready = ~(out_valid & ~out_ready).
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, in_a, in_b, in_cin (add mode only), in_sub (0 add, 1 subtract)
//        out_valid/out_ready, out_sum, out_cout (sub mode: 1 = no borrow), out_ovf (signed overflow)
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // The only stall condition is a result the consumer has not taken yet.
   // Bubbles are not squeezed out, so a single advance signal moves every stage.
   assign adv      = ~(out_valid & ~out_ready);
   assign in_ready = adv;

   // Subtraction is A + ~B + 1; in_cin is ignored in that mode.
   assign b_eff = (in_sub == MODE_SUB) ? ~in_b : in_b;
   assign c0    = (in_sub == MODE_SUB) ? 1'b1 : in_cin;

   // Stage k adds operand slice k. Its operand registers (op_a/op_b) carry
   // slices k..STAGES-1 (the not-yet-added upper bits, shrinking each stage);
   // acc collects slices 0..k of the sum (growing each stage), so the final
   // stage's acc is the complete, aligned result.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int OW = WIDTH - k * SEG;   // operand bits still pending
      localparam int AW = (k + 1) * SEG;     // sum bits complete after this stage

      logic [OW-1:0]  op_a;
      logic [OW-1:0]  op_b;
      logic           cin_k;
      logic           vld;
      logic [SEG-1:0] seg_sum;
      logic           cout;
      logic           c_msb;
      logic [AW-1:0]  acc;

      if (k == 0) begin : g_head
         // Stage 0 adds straight from the input port in the acceptance cycle.
         assign op_a  = in_a;
         assign op_b  = b_eff;
         assign cin_k = c0;
         assign acc   = seg_sum;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld <= 1'b0;
            end else if (adv) begin
               vld <= in_valid;
            end
         end
      end else begin : g_body
         // Deskew: lower sum slices wait here for their upper slices.
         logic [k*SEG-1:0] lo_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld  <= 1'b0;
               op_a <= '0;
               op_b <= '0;
               lo_q <= '0;
            end else if (adv) begin
               vld  <= g_stage[k-1].vld;
               // Skew: drop the slice the previous stage just consumed.
               op_a <= g_stage[k-1].op_a[OW+SEG-1:SEG];
               op_b <= g_stage[k-1].op_b[OW+SEG-1:SEG];
               lo_q <= g_stage[k-1].acc;
            end
         end

         assign cin_k = g_stage[k-1].cout;
         assign acc   = {seg_sum, lo_q};
      end

      addsub_segment #(
         .SEG (SEG)
      ) u_seg (
         .clk   (clk),
         .rst   (rst),
         .en    (adv),
         .a     (op_a[SEG-1:0]),
         .b     (op_b[SEG-1:0]),
         .cin   (cin_k),
         .sum   (seg_sum),
         .cout  (cout),
         .c_msb (c_msb)
      );

      // Only the top segment's MSB carry matters (overflow); lower taps are dropped.
      if (k < STAGES - 1) begin : g_tap
         logic c_msb_unused;
         assign c_msb_unused = c_msb;
      end
   end

   assign out_valid = g_stage[STAGES-1].vld;
   assign out_sum   = g_stage[STAGES-1].acc;
   assign out_cout  = g_stage[STAGES-1].cout;
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign out_ovf   = g_stage[STAGES-1].c_msb ^ g_stage[STAGES-1].cout;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: three instances (STAGES = 4, 1, 8) share one stimulus stream.
// Each instance has its own scoreboard; only the STAGES=4 instance sees backpressure.
module tb_pipelined_addsub;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_ready;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference result {ovf, cout, sum}; overflow from the operand/result sign rule.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      logic [31:0] bb;
      logic [32:0] full;
      logic        ovf;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
      return {ovf, full[32], full[31:0]};
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int ST = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);

      logic          in_ready;
      logic          out_valid;
      logic [W-1:0]  out_sum;
      logic          out_cout;
      logic          out_ovf;
      logic          ordy;
      logic [33:0]   q[$];
      int            n_out = 0;

      assign ordy = (gi == 0) ? out_ready : 1'b1;

      pipelined_addsub #(
         .WIDTH  (W),
         .STAGES (ST)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_a      (in_a),
         .in_b      (in_b),
         .in_cin    (in_cin),
         .in_sub    (in_sub),
         .out_valid (out_valid),
         .out_ready (ordy),
         .out_sum   (out_sum),
         .out_cout  (out_cout),
         .out_ovf   (out_ovf)
      );

      // Sampled mid-cycle: decide what the coming rising edge will do.
      always @(negedge clk) begin
         logic [33:0] exp;
         chk($sformatf("s%0d_in_ready", ST), 64'(in_ready), 64'(!(out_valid && !ordy)));
         if (out_valid && ordy) begin
            n_out++;
            if (q.size() == 0) begin
               chk($sformatf("s%0d_unexpected_out", ST), 64'(q.size()), 64'd1);
            end else begin
               exp = q.pop_front();
               chk($sformatf("s%0d_result", ST), 64'({out_ovf, out_cout, out_sum}), 64'(exp));
            end
         end
         if (rst) q.delete();
         else if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub));
      end
   end

   // Present one beat starting at posedge+1; returns the cycle count seen at the
   // negedge just before the accepting edge.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output int acc_cyc);
      logic acc;
      acc      = 1'b0;
      acc_cyc  = -1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = g_dut[0].in_ready;
         if (acc) acc_cyc = cyc;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("drive_timeout", 64'(acc), 64'd1);
   endtask

   // One isolated beat: check latency and result on all three instances.
   task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] e_sum,
                           input logic e_cout, input logic e_ovf);
      int          acc_cyc;
      int          lat[3];
      logic [33:0] res[3];
      lat = '{-1, -1, -1};
      res = '{34'd0, 34'd0, 34'd0};
      drive(a, b, cin, sub, acc_cyc);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (lat[0] < 0 && g_dut[0].out_valid) begin
            lat[0] = cyc;
            res[0] = {g_dut[0].out_ovf, g_dut[0].out_cout, g_dut[0].out_sum};
         end
         if (lat[1] < 0 && g_dut[1].out_valid) begin
            lat[1] = cyc;
            res[1] = {g_dut[1].out_ovf, g_dut[1].out_cout, g_dut[1].out_sum};
         end
         if (lat[2] < 0 && g_dut[2].out_valid) begin
            lat[2] = cyc;
            res[2] = {g_dut[2].out_ovf, g_dut[2].out_cout, g_dut[2].out_sum};
         end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      chk({tag, "_s4_latency"}, 64'(lat[0] - acc_cyc), 64'd4);
      chk({tag, "_s1_latency"}, 64'(lat[1] - acc_cyc), 64'd1);
      chk({tag, "_s8_latency"}, 64'(lat[2] - acc_cyc), 64'd8);
      chk({tag, "_s4_sum"},  64'(res[0][31:0]), 64'(e_sum));
      chk({tag, "_s4_cout"}, 64'(res[0][32]),   64'(e_cout));
      chk({tag, "_s4_ovf"},  64'(res[0][33]),   64'(e_ovf));
      chk({tag, "_s1_res"},  64'(res[1]), 64'({e_ovf, e_cout, e_sum}));
      chk({tag, "_s8_res"},  64'(res[2]), 64'({e_ovf, e_cout, e_sum}));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int acc_cyc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 64'(g_dut[0].out_valid), 64'd0);
      chk("rst_out_sum",   64'(g_dut[0].out_sum),   64'd0);
      chk("rst_out_cout",  64'(g_dut[0].out_cout),  64'd0);
      chk("rst_out_ovf",   64'(g_dut[0].out_ovf),   64'd0);
      chk("rst_in_ready",  64'(g_dut[0].in_ready),  64'd1);
      @(posedge clk);
      #1;

      // Directed arithmetic cases
      one_shot("add_basic",  32'd50,         32'd100,        1'b0, 1'b0, 32'd150,        1'b0, 1'b0);
      one_shot("pos_ovf",    32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1);
      one_shot("neg_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h7FFF_FFFF,  1'b1, 1'b1);
      one_shot("sub_borrow", 32'd100,        32'd200,        1'b0, 1'b1, 32'hFFFF_FF9C,  1'b0, 1'b0);
      one_shot("neg_cin",    32'hFFFF_FFCE,  32'hFFFF_FF9C,  1'b1, 1'b0, 32'hFFFF_FF6B,  1'b1, 1'b0);
      one_shot("ripple",     32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 32'd0,          1'b1, 1'b0);

      // Backpressure: 8 back-to-back beats, consumer stalls for cycles 6..8
      base = g_dut[0].n_out;
      fork
         begin
            int d;
            for (int i = 0; i < 8; i++) drive(32'(i), 32'(10 * i), 1'b0, 1'b0, d);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (15) @(posedge clk);
      #1;
      chk("bp_emit_count", 64'(g_dut[0].n_out - base), 64'd8);
      chk("bp_sb_empty",   64'(g_dut[0].q.size()),     64'd0);

      // Reset mid-flight: three beats in the pipe are discarded
      base = g_dut[0].n_out;
      for (int i = 0; i < 3; i++) drive(32'(1000 + i), 32'(7 * i), 1'b0, 1'b0, acc_cyc);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 64'(g_dut[0].out_valid), 64'd0);
      chk("midrst_out_sum",   64'(g_dut[0].out_sum),   64'd0);
      chk("midrst_out_cout",  64'(g_dut[0].out_cout),  64'd0);
      chk("midrst_out_ovf",   64'(g_dut[0].out_ovf),   64'd0);
      chk("midrst_s8_valid",  64'(g_dut[2].out_valid), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_no_emit", 64'(g_dut[0].n_out - base), 64'd0);

      // After reset traffic flows again; cin must be ignored in sub mode
      one_shot("sub_cin_ign", 32'd100, 32'd200, 1'b1, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("final_s4_sb_empty", 64'(g_dut[0].q.size()), 64'd0);
      chk("final_s1_sb_empty", 64'(g_dut[1].q.size()), 64'd0);
      chk("final_s8_sb_empty", 64'(g_dut[2].q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
